add_seq_nibble: RTL and testbench



---
 rtl/add_seq_nibble_if.sv | 26 ++
 rtl/add_seq_nibble.sv | 137 +++++++++++++
 tb/tb_add_seq_nibble.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/add_seq_nibble_if.sv
// add_seq_nibble_if: start/operand/result bundle for the nibble-serial adder.
// The requester drives through the master modport; add_seq_nibble uses slave.
interface add_seq_nibble_if #(
    parameter int NIBBLES = 8
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;

    modport master (
        output start, a, b, ci,
        input  busy, done, s, co
    );

    modport slave (
        input  start, a, b, ci,
        output busy, done, s, co
    );
endinterface

// File: rtl/add_seq_nibble.sv
// add_seq_nibble: W = 4*NIBBLES bit adder that pushes one nibble per clock
// through a single 4-bit ripple slice (add4 semantics: ci, a, b -> s, co).
// Operands are captured on an accepted start; the sum is assembled in s and
// the final carry lands in co together with a one-cycle done pulse.
//
// Optional build macro ADD_SEQ_EARLY_TERM_EN: finish as soon as the carry is
// zero and all remaining operand nibbles are zero. Results are unchanged;
// only the latency becomes data dependent (1..NIBBLES edges).
module add_seq_nibble #(
    parameter int NIBBLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    add_seq_nibble_if.slave   bus
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [0:0]       IDLE     = 1'b0;
    localparam logic [0:0]       RUN      = 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    // One 4-bit ripple slice: returns {carry_out, sum}.
    function automatic logic [4:0] add4(input logic       c_in,
                                        input logic [3:0] x,
                                        input logic [3:0] y);
        return {1'b0, x} + {1'b0, y} + {4'b0000, c_in};
    endfunction

    logic [0:0]       state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [W-1:0]     s_q, s_d;
    logic             co_q, co_d;
    logic             done_q, done_d;

    logic [4:0]       slice_res;
    logic             rest_zero;
    logic             last_nib;

    // The operand registers shift right one nibble per RUN cycle, so the
    // slice always consumes the low nibble and the rest of the operand is
    // whatever is left above it.
    assign slice_res = add4(carry_q, a_q[3:0], b_q[3:0]);
    assign last_nib  = (k_q == LAST_IDX);

`ifdef ADD_SEQ_EARLY_TERM_EN
    assign rest_zero = ((a_q >> 4) == '0) && ((b_q >> 4) == '0);
`else
    assign rest_zero = 1'b0;
`endif

    // Next-state: accept in IDLE, one slice step per RUN cycle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        k_d     = k_q;
        s_d     = s_q;
        co_d    = co_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.ci;
                    k_d     = '0;
                    s_d     = '0;
                    co_d    = 1'b0;
                    state_d = RUN;
                end
            end

            RUN: begin
                // Write the slice sum into nibble position k.
                for (int n = 0; n < NIBBLES; n++) begin
                    if (k_q == IDX_W'(n)) begin
                        s_d[4*n +: 4] = slice_res[3:0];
                    end
                end
                carry_d = slice_res[4];
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;

                // Early finish only when no carry is pending, so co is 0
                // in that case and the untouched upper s nibbles are
                // already correct from the start-time clear.
                if (last_nib || (!slice_res[4] && rest_zero)) begin
                    co_d    = slice_res[4];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    k_d = k_q + IDX_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; asynchronous reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            s_q     <= s_d;
            co_q    <= co_d;
            done_q  <= done_d;
        end
    end

    // All outputs come straight from registers.
    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.co   = co_q;

endmodule

// File: tb/tb_add_seq_nibble.sv
// tb_add_seq_nibble: directed and random checks of add_seq_nibble with an
// 8-nibble instance and a 1-nibble instance (exhaustive slice sweep).
module tb_add_seq_nibble;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    add_seq_nibble_if #(.NIBBLES(8)) bus8 ();
    add_seq_nibble_if #(.NIBBLES(1)) bus1 ();

    add_seq_nibble #(.NIBBLES(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    add_seq_nibble #(.NIBBLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected edges from start to done, from the arithmetic definition.
    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic ci);
`ifdef ADD_SEQ_EARLY_TERM_EN
        logic [63:0] aa, bb, m, low;
        int sh;
        aa = {32'b0, a};
        bb = {32'b0, b};
        for (int k = 0; k < 7; k++) begin
            sh  = 4 * (k + 1);
            m   = (64'd1 << sh) - 64'd1;
            low = (aa & m) + (bb & m) + {63'b0, ci};
            if ((low >> sh) == 64'd0 && (aa >> sh) == 64'd0 && (bb >> sh) == 64'd0)
                return k + 1;
        end
        return 8;
`else
        if (a == b && ci && 1'b0) return 0;
        return 8;
`endif
    endfunction

    // Full 8-nibble operation; on return the bench sits in the done cycle.
    task automatic op8(input logic [31:0] a, input logic [31:0] b, input logic ci,
                       input string tag, input bit inject);
        logic [32:0] exp_sum;
        int exp_lat;
        int lat;
        exp_sum = {1'b0, a} + {1'b0, b} + {32'b0, ci};
        exp_lat = ref_lat(a, b, ci);
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        bus8.ci    = ci;
        tick();
        chk({tag, " busy@E0"}, {62'b0, bus8.busy, bus8.done}, 64'h2);
        chk({tag, " s clr"}, {32'b0, bus8.s}, 64'h0);
        bus8.start = 1'b0;
        bus8.a     = $urandom;
        bus8.b     = $urandom;
        bus8.ci    = 1'($urandom);
        lat = 0;
        while (bus8.done !== 1'b1 && lat < 40) begin
            if (inject && lat == 2 && exp_lat > 3) begin
                bus8.start = 1'b1;
                bus8.a     = 32'hFFFF_FFFF;
                bus8.b     = 32'hFFFF_FFFF;
            end else begin
                bus8.start = 1'b0;
            end
            tick();
            lat++;
        end
        bus8.start = 1'b0;
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " s"}, {32'b0, bus8.s}, {32'b0, exp_sum[31:0]});
        chk({tag, " co"}, {63'b0, bus8.co}, {63'b0, exp_sum[32]});
        chk({tag, " busy@done"}, {63'b0, bus8.busy}, 64'h0);
    endtask

    // One cycle past done: pulse gone, result held.
    task automatic after_done(input string tag, input logic [31:0] s_exp, input logic co_exp);
        tick();
        chk({tag, " done 1cyc"}, {62'b0, bus8.done, bus8.busy}, 64'h0);
        chk({tag, " hold"}, {31'b0, bus8.co, bus8.s}, {31'b0, co_exp, s_exp});
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rc;
        logic [32:0] rs;
        int          pulses;

        rst_n      = 1'b0;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus8.ci    = 1'b0;
        bus1.start = 1'b0;
        bus1.a     = '0;
        bus1.b     = '0;
        bus1.ci    = 1'b0;
        #12;
        chk("reset8", {29'b0, bus8.busy, bus8.done, bus8.co, bus8.s}, 64'h0);
        chk("reset1", {57'b0, bus1.busy, bus1.done, bus1.co, bus1.s}, 64'h0);
        rst_n = 1'b1;
        tick();

        // Directed cases
        op8(32'h0000_000F, 32'h0000_0001, 1'b0, "t1", 1'b0);
        after_done("t1", 32'h0000_0010, 1'b0);
        op8(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "t2", 1'b0);
        after_done("t2", 32'h0000_0000, 1'b1);
        op8(32'h1234_5678, 32'h8765_4321, 1'b0, "t3a", 1'b0);
        op8(32'h1234_5678, 32'h8765_4321, 1'b1, "t3b", 1'b0);
        after_done("t3b", 32'h9999_999A, 1'b0);

        // Start while busy is ignored; start in the done cycle is accepted
        op8(32'h0000_0005, 32'h0000_0003, 1'b0, "t4a", 1'b1);
        op8(32'h8000_0000, 32'h8000_0000, 1'b0, "t4b", 1'b0);
        after_done("t4b", 32'h0000_0000, 1'b1);

        // Asynchronous reset mid-operation
        bus8.start = 1'b1;
        bus8.a     = 32'hAAAA_AAAA;
        bus8.b     = 32'h5555_5555;
        bus8.ci    = 1'b0;
        tick();
        bus8.start = 1'b0;
        tick();
        tick();
        chk("t5 partial", {31'b0, bus8.busy, bus8.s}, {31'b0, 1'b1, 32'h0000_00FF});
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5 async rst", {29'b0, bus8.busy, bus8.done, bus8.co, bus8.s}, 64'h0);
        #10;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) pulses++;
        end
        chk("t5 no done", 64'(pulses), 64'h0);
        op8(32'h0000_0001, 32'h0000_0001, 1'b0, "t5b", 1'b0);
        after_done("t5b", 32'h0000_0002, 1'b0);

        // Random operands, some with sparse upper nibbles
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom);
            if (i % 3 == 1) begin
                ra = ra >> (4 * $urandom_range(1, 7));
                rb = rb >> (4 * $urandom_range(1, 7));
            end
            rs = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
            op8(ra, rb, rc, "rand", 1'b0);
            after_done("rand", rs[31:0], rs[32]);
        end

        // Exhaustive single-nibble sweep
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    bus1.start = 1'b1;
                    bus1.a     = 4'(x);
                    bus1.b     = 4'(y);
                    bus1.ci    = 1'(c);
                    tick();
                    bus1.start = 1'b0;
                    chk("n1 busy", {62'b0, bus1.busy, bus1.done}, 64'h2);
                    tick();
                    chk("n1 result", {58'b0, bus1.done, bus1.co, bus1.s},
                        {58'b0, 1'b1, 5'(x + y + c)});
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
